// File: rtl/mag_sq_prep_if.sv
// Handshake bundle for mag_sq_prep: sample pair in, squared magnitude out.
// slave = block side, master = producer/consumer side.
interface mag_sq_prep_if #(
  parameter int IN_W = 8
);
  logic signed [IN_W-1:0]   x_in;
  logic signed [IN_W-1:0]   y_in;
  logic                     in_valid;
  logic                     in_ready;
  logic        [2*IN_W-1:0] num;
  logic                     num_valid;
  logic                     num_ready;

  modport slave (
    input  x_in,
    input  y_in,
    input  in_valid,
    input  num_ready,
    output in_ready,
    output num,
    output num_valid
  );

  modport master (
    output x_in,
    output y_in,
    output in_valid,
    output num_ready,
    input  in_ready,
    input  num,
    input  num_valid
  );
endinterface

// File: rtl/mag_sq_prep.sv
// mag_sq_prep: x^2 + y^2 via iterative shift-add, valid/ready on both sides.
// Ports: CLK, RST (sync, active-high), bus (mag_sq_prep_if.slave):
//   x_in/y_in/in_valid/in_ready in, num/num_valid/num_ready out.
// Option MAG_SQ_PREP_PAR_EN: square |x| and |y| concurrently (latency IN_W).
module mag_sq_prep #(
  parameter int IN_W = 8
) (
  input logic         CLK,
  input logic         RST,
  mag_sq_prep_if.slave bus
);
  localparam int OW = 2 * IN_W;
  localparam int CW = $clog2(IN_W);
  localparam logic [CW-1:0] LAST = CW'(IN_W - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SQX  = 2'd1;
  localparam logic [1:0] SQY  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  function automatic logic [IN_W-1:0] mag(
    input logic [IN_W-1:0] v
  );
    // -2^(IN_W-1) negates to itself, which read unsigned is the magnitude
    return v[IN_W-1] ? (-v) : v;
  endfunction

  logic [1:0]      state;
  logic [OW-1:0]   acc;
  logic [OW-1:0]   mcand;
  logic [IN_W-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic [OW-1:0]   pa;

  assign pa = mplier[0] ? mcand : '0;

`ifdef MAG_SQ_PREP_PAR_EN
  logic [OW-1:0]   acc2;
  logic [OW-1:0]   mcand2;
  logic [IN_W-1:0] mplier2;
  logic [OW-1:0]   pb;

  assign pb = mplier2[0] ? mcand2 : '0;
`else
  logic [IN_W-1:0] mag_y;
`endif

  assign bus.in_ready  = (state == IDLE);
  assign bus.num_valid = (state == DONE);
  assign bus.num       = acc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
`ifdef MAG_SQ_PREP_PAR_EN
      acc2    <= '0;
      mcand2  <= '0;
      mplier2 <= '0;
`else
      mag_y  <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.in_valid) begin
            mcand  <= {{IN_W{1'b0}}, mag(bus.x_in)};
            mplier <= mag(bus.x_in);
            acc    <= '0;
            cnt    <= '0;
`ifdef MAG_SQ_PREP_PAR_EN
            mcand2  <= {{IN_W{1'b0}}, mag(bus.y_in)};
            mplier2 <= mag(bus.y_in);
            acc2    <= '0;
`else
            mag_y  <= mag(bus.y_in);
`endif
            state  <= SQX;
          end
        end
        SQX: begin
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
`ifdef MAG_SQ_PREP_PAR_EN
          mcand2  <= mcand2 << 1;
          mplier2 <= mplier2 >> 1;
          acc     <= acc + pa;
          acc2    <= acc2 + pb;
          if (cnt == LAST) begin
            // fold both partial squares into num on DONE entry
            acc   <= acc + pa + acc2 + pb;
            cnt   <= '0;
            state <= DONE;
          end
`else
          acc    <= acc + pa;
          if (cnt == LAST) begin
            // reload the shared datapath with |y|
            mcand  <= {{IN_W{1'b0}}, mag_y};
            mplier <= mag_y;
            cnt    <= '0;
            state  <= SQY;
          end
`endif
        end
        SQY: begin
          acc    <= acc + pa;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            cnt   <= '0;
            state <= DONE;
          end
        end
        DONE: begin
          if (bus.num_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mag_sq_prep.sv
// Directed bench for mag_sq_prep: reset, squares, backpressure,
// mid-flight reset and back-to-back pairs.
module tb_mag_sq_prep;
`ifdef MAG_SQ_PREP_PAR_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif
  localparam int PER = LAT + 2;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  mag_sq_prep_if #(.IN_W(8)) bus ();

  mag_sq_prep #(.IN_W(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic signed [7:0] x,
                      input logic signed [7:0] y);
    bus.x_in     = x;
    bus.y_in     = y;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (bus.num_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.x_in     = 8'sd5;
    bus.y_in     = 8'sd5;
    bus.num_ready = 1'b1;
    step();
    step();
    bus.in_valid = 1'b0;
    rst          = 1'b0;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_in_ready got %b want 1", bus.in_ready);
    end
    tests++;
    if (bus.num_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_num_valid got %b want 0", bus.num_valid);
    end
    tests++;
    if (bus.num !== 16'd0) begin
      fails++;
      $display("FAIL rst_num got %0d want 0", bus.num);
    end
    step();
    tests++;
    if (bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_no_accept in_ready %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_basic();
    int cyc;
    bus.num_ready = 1'b1;
    send(8'sd3, 8'sd4);
    tests++;
    if (bus.in_ready !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy in_ready %b want 0", bus.in_ready);
    end
    wait_valid(cyc);
    tests++;
    if (cyc != LAT) begin
      fails++;
      $display("FAIL basic_latency got %0d want %0d", cyc, LAT);
    end
    tests++;
    if (bus.num !== 16'd25) begin
      fails++;
      $display("FAIL basic_num got %0d want 25", bus.num);
    end
    step();
    tests++;
    if (bus.num_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL basic_release valid %b ready %b want 0 1",
               bus.num_valid, bus.in_ready);
    end
  endtask

  task automatic test_boundary();
    int cyc;
    bus.num_ready = 1'b1;
    send(-8'sd128, -8'sd128);
    wait_valid(cyc);
    tests++;
    if (cyc != LAT || bus.num !== 16'h8000) begin
      fails++;
      $display("FAIL max_num got %h at %0d want 8000 at %0d",
               bus.num, cyc, LAT);
    end
    step();
    send(8'sd0, 8'sd0);
    wait_valid(cyc);
    tests++;
    if (cyc != LAT || bus.num !== 16'd0) begin
      fails++;
      $display("FAIL zero_num got %0d at %0d want 0 at %0d",
               bus.num, cyc, LAT);
    end
    step();
  endtask

  task automatic test_backpressure();
    int cyc;
    int bad;
    bus.num_ready = 1'b0;
    send(-8'sd7, 8'sd5);
    wait_valid(cyc);
    tests++;
    if (cyc != LAT || bus.num !== 16'd74) begin
      fails++;
      $display("FAIL bp_num got %0d at %0d want 74 at %0d",
               bus.num, cyc, LAT);
    end
    bus.x_in     = 8'sd100;
    bus.y_in     = 8'sd100;
    bus.in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.num !== 16'd74 || bus.num_valid !== 1'b1 ||
          bus.in_ready !== 1'b0)
        bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL bp_hold bad cycles %0d want 0 (num %0d)",
               bad, bus.num);
    end
    bus.in_valid  = 1'b0;
    bus.num_ready = 1'b1;
    step();
    tests++;
    if (bus.num_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release valid %b ready %b want 0 1",
               bus.num_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    int seen;
    bus.num_ready = 1'b1;
    send(8'sd12, -8'sd9);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (bus.num !== 16'd0 || bus.num_valid !== 1'b0 ||
        bus.in_ready !== 1'b1) begin
      fails++;
      $display("FAIL mid_rst num %0d valid %b ready %b want 0 0 1",
               bus.num, bus.num_valid, bus.in_ready);
    end
    seen = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      step();
      if (bus.num_valid) seen++;
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL mid_rst_ghost pulses %0d want 0", seen);
    end
    send(8'sd1, 8'sd1);
    wait_valid(cyc);
    tests++;
    if (cyc != LAT || bus.num !== 16'd2) begin
      fails++;
      $display("FAIL mid_rst_next got %0d at %0d want 2 at %0d",
               bus.num, cyc, LAT);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic signed [7:0] xs [3];
    logic signed [7:0] ys [3];
    logic [15:0] want [3];
    logic [15:0] got [3];
    int t [3];
    int idx;
    int n;
    logic acc_now;
    xs = '{8'sd3, 8'sd6, -8'sd1};
    ys = '{8'sd4, 8'sd8, 8'sd0};
    want = '{16'd25, 16'd100, 16'd1};
    bus.num_ready = 1'b1;
    idx = 0;
    n   = 0;
    bus.x_in     = xs[0];
    bus.y_in     = ys[0];
    bus.in_valid = 1'b1;
    for (int cyc = 0; cyc < 300 && n < 3; cyc++) begin
      if (bus.num_valid) begin
        got[n] = bus.num;
        t[n]   = cyc;
        n++;
      end
      acc_now = bus.in_valid && bus.in_ready;
      step();
      if (acc_now) begin
        idx++;
        if (idx < 3) begin
          bus.x_in = xs[idx];
          bus.y_in = ys[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    tests++;
    if (n != 3) begin
      fails++;
      $display("FAIL b2b_count got %0d results want 3", n);
    end else begin
      for (int i = 0; i < 3; i++) begin
        tests++;
        if (got[i] !== want[i]) begin
          fails++;
          $display("FAIL b2b_num%0d got %0d want %0d",
                   i, got[i], want[i]);
        end
      end
      tests++;
      if (t[1] - t[0] != PER || t[2] - t[1] != PER) begin
        fails++;
        $display("FAIL b2b_spacing got %0d %0d want %0d",
                 t[1] - t[0], t[2] - t[1], PER);
      end
    end
    step();
  endtask

  initial begin
    rst           = 1'b1;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.in_valid  = 1'b0;
    bus.num_ready = 1'b0;
    test_reset();
    test_basic();
    test_boundary();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mag_sq_prep.md
# mag_sq_prep

Upstream operand stage for the `square_root` block. It accepts a signed sample pair (x, y) through a valid/ready handshake and computes x² + y² with an iterative shift-add multiplier. It then presents the 16-bit result on `num` behind a valid/ready handshake. The downstream root stage then yields the vector magnitude |(x, y)|.

## Interface
- `IN_W`, default 8: signed input sample width, legal range 2..8. Output width is fixed at 2*IN_W = 16 at the default.
- `CLK` input 1: sole clock; all state updates on the rising edge.
- `RST` input 1: synchronous, active-high reset, sampled on rising `CLK`.
- `x_in` input IN_W: signed two's-complement x sample.
- `y_in` input IN_W: signed two's-complement y sample.
- `in_valid` input 1: `x_in`/`y_in` are valid this cycle.
- `in_ready` output 1: block can accept a pair this cycle.
- `num` output 2*IN_W: unsigned x² + y²; feeds `square_root.num`.
- `num_valid` output 1: `num` holds a completed result.
- `num_ready` input 1: downstream consumes `num` this cycle.

## Operation
- FSM states:
  - IDLE: `in_ready`=1; an accept occurs when `in_valid`&`in_ready`.
  - SQX: square |x|.
  - SQY: square |y| and accumulate.
  - DONE: `num_valid`=1.
- On accept:
  - Latch |x_in| and |y_in| as IN_W-bit unsigned magnitudes. -2^(IN_W-1) maps to 2^(IN_W-1), which fits unsigned.
  - Clear the accumulator and bit counter; go to SQX.
- SQX, one bit per cycle, LSB first, IN_W cycles:
  - If the current multiplier bit is 1, add the left-shifted multiplicand (2*IN_W bits) to the accumulator.
  - Then shift and increment the counter.
  - After bit IN_W-1, go to SQY with the counter cleared.
- SQY: same procedure using |y|, accumulating onto the x² result. After bit IN_W-1, go to DONE.
- Arithmetic:
  - Each square is at most 2^(2*IN_W-2), so the sum is at most 2^(2*IN_W-1).
  - The accumulator never overflows 2*IN_W bits; no saturation logic.
- DONE:
  - `num` equals the accumulator, held stable while `num_valid`&!`num_ready`.
  - On `num_ready`, go to IDLE; `num_valid` drops the next cycle.
- `in_valid` outside IDLE is ignored; inputs are not sampled and the upstream must hold them.
- `in_ready` is a pure state decode with no combinational path from `num_ready`.

## Timing
- Reset values:
  - State is IDLE.
  - `in_ready`=1, `num_valid`=0.
  - `num`=0, accumulator=0, counter=0.
- Latency (default build): 2*IN_W cycles from the accept edge to `num_valid` high. This is 16 at IN_W=8: `num_valid` is first high in the cycle after the 16th edge following accept.
- Throughput: one pair per 2*IN_W+2 cycles with `num_ready` held high: 1 IDLE cycle, 2*IN_W compute cycles, 1 DONE cycle.
- Reset mid-operation (SQX/SQY/DONE):
  - Any in-flight result is discarded.
  - Outputs return to their reset values on that edge.
  - No `num_valid` pulse is produced for the aborted pair.
- Simultaneous `RST` and `in_valid`: reset wins; nothing is accepted.
- `num_valid` never deasserts without a `num_ready` handshake, except on reset.

## Configuration
- `MAG_SQ_PREP_PAR_EN`, defined:
  - Two shift-add datapaths square |x| and |y| concurrently.
  - SQY is removed; SQX runs IN_W cycles, then the two products are summed into `num` on the DONE entry edge.
  - Latency is IN_W cycles (8 at default); throughput is one pair per IN_W+2 cycles.
- Undefined: single shared datapath, sequential SQX→SQY, latency 2*IN_W.
- Results are bit-identical in both builds.

## Test plan
- x=3, y=4 accepted with `num_ready`=1 → `num`=25 and `num_valid` high 16 cycles after accept (8 with PAR_EN); downstream root gives 5.
- x=-128, y=-128 → `num`=32768 (0x8000), no overflow. x=0, y=0 → `num`=0 with `num_valid` still asserted.
- x=-7, y=5, `num_ready`=0 for 10 cycles after `num_valid` → `num`=74 stable throughout, `in_ready`=0, and a second `in_valid` pair is ignored. Raise `num_ready` → IDLE next cycle.
- Pair x=12, y=-9 accepted, `RST` pulsed 5 cycles later → `num`=0, `num_valid`=0, `in_ready`=1 on the next cycle. A following pair x=1, y=1 yields `num`=2.
- Back-to-back pairs (3,4), (6,8), (-1,0) with `in_valid` held and `num_ready`=1 → results 25, 100, 1 in order, spaced 18 cycles apart (10 with PAR_EN).
